// File: rtl/prim_skid_flop.sv
// Two-entry valid/ready register slice (main + skid register) with registered ready_o/valid_o/q_o.
// Optional output stall counter enabled by defining PRIM_SKID_FLOP_STALL_CNT_EN.
module prim_skid_flop #(
  parameter int unsigned           Width      = 1,
  parameter logic [Width-1:0]      ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] d_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] q_o,
  output logic [1:0]       count_o,
  output logic [15:0]      stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= ResetValue;
      skid_q  <= ResetValue;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (valid_i) begin
          main_d  = d_i;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({valid_i, ready_i})
          2'b11: main_d = d_i;
          2'b01: state_d = EMPTY;
          2'b10: begin
            skid_d  = d_i;
            state_d = TWO;
          end
          default: ;
        endcase
      end
      TWO: begin
        // Upstream is blocked here, so the skid entry is the only source for main.
        if (ready_i) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign valid_o = (state_q != EMPTY);
  assign ready_o = (state_q != TWO);
  assign q_o     = main_q;
  assign count_o = state_q;

`ifdef PRIM_SKID_FLOP_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (valid_o && !ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prim_skid_flop.sv
// Bench for prim_skid_flop (Width=8, ResetValue=8'h5A): vector table for reset/backpressure/mid-reset,
// queue scoreboard for streaming and random traffic, stall counter check for both macro settings.
module tb_prim_skid_flop;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] d_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] q_o;
  logic [1:0] count_o;
  logic [15:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  prim_skid_flop #(
    .Width      (8),
    .ResetValue (8'h5A)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .d_i         (d_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .q_o         (q_o),
    .count_o     (count_o),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic       r;
    logic [7:0] d;
    logic       ev;
    logic       er;
    logic [1:0] ec;
    logic [7:0] eq;
  } vec_t;

  vec_t tbl [16];

  logic [7:0]  sb_q [$];
  logic [7:0]  last_q;
  logic [15:0] exp_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of scoreboard-tracked traffic; inputs are already driven.
  task automatic step();
    logic       in_x;
    logic       out_x;
    logic [7:0] popped;
    in_x  = valid_i && (sb_q.size() < 2);
    out_x = ready_i && (sb_q.size() > 0);
    if (out_x) begin
      popped = sb_q.pop_front();
      chk("sb_data", {24'd0, q_o}, {24'd0, popped});
      last_q = popped;
    end
    if ((sb_q.size() > 0 || out_x) && !ready_i && exp_stall != 16'hFFFF) exp_stall++;
    @(posedge clk_i);
    #1;
    if (in_x) sb_q.push_back(d_i);
    if (sb_q.size() > 0) last_q = sb_q[0];
    chk("valid_o", {31'd0, valid_o}, {31'd0, (sb_q.size() > 0)});
    chk("ready_o", {31'd0, ready_o}, {31'd0, (sb_q.size() < 2)});
    chk("count_o", {30'd0, count_o}, sb_q.size());
    chk("q_o", {24'd0, q_o}, {24'd0, last_q});
`ifdef PRIM_SKID_FLOP_STALL_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt_o}, {16'd0, exp_stall});
`else
    chk("stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
`endif
  endtask

  initial begin
    //                 rst   v     r     d      ev    er    ec     eq
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b1, 2'd0, 8'h5A};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b1, 2'd0, 8'h5A};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 2'd1, 8'h11};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 2'd2, 8'h11};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 2'd2, 8'h11};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 2'd2, 8'h11};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 2'd1, 8'h22};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 2'd1, 8'h33};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 8'h33};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h33};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 2'd1, 8'h44};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 2'd2, 8'h44};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 2'd0, 8'h5A};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 8'h5A};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 2'd1, 8'h77};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 8'h77};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; d_i = '0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 16; i++) begin
      rst_i   = tbl[i].rst;
      valid_i = tbl[i].v;
      ready_i = tbl[i].r;
      d_i     = tbl[i].d;
      @(posedge clk_i);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_ready", i), {31'd0, ready_o}, {31'd0, tbl[i].er});
      chk($sformatf("vec%0d_count", i), {30'd0, count_o}, {30'd0, tbl[i].ec});
      chk($sformatf("vec%0d_q", i), {24'd0, q_o}, {24'd0, tbl[i].eq});
    end

    // Slice is EMPTY holding 8'h77; stall counter was cleared by the reset at vector 12.
    last_q    = 8'h77;
    exp_stall = 16'd0;

    ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      valid_i = 1'b1;
      d_i     = 8'(i);
      step();
    end
    valid_i = 1'b0;
    step();
    step();

    for (int i = 0; i < 10000; i++) begin
      if (!(valid_i && !ready_o)) begin
        valid_i = 1'($urandom_range(0, 1));
        d_i     = 8'($urandom);
      end
      ready_i = 1'($urandom_range(0, 1));
      step();
    end

    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    step();
    step();
    chk("drained", sb_q.size(), 32'd0);

    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    valid_i = 1'b1;
    d_i     = 8'hC3;
    ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
`ifdef PRIM_SKID_FLOP_STALL_CNT_EN
    repeat (70000) @(posedge clk_i);
    #1;
    chk("stall_sat", {16'd0, stall_cnt_o}, 32'h0000FFFF);
`else
    repeat (20) @(posedge clk_i);
    #1;
    chk("stall_off", {16'd0, stall_cnt_o}, 32'd0);
`endif
    chk("stall_hold_valid", {31'd0, valid_o}, 32'd1);
    chk("stall_hold_q", {24'd0, q_o}, 32'h000000C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
